wts_channel_writer: RTL and testbench

Write-side counterpart of the per-channel register selector in the wave table sound core. It accepts CPU-side register writes over a four-phase request/acknowledge handshake and routes each write into one of six per-channel registers (channels A–F). Those registers feed the selector and the synthesis pipeline. A write is never committed while the time-slot generator is servicing the target channel, so the pipeline never sees a register change mid-slot.

---
 rtl/wts_channel_writer.sv | 129 ++++++++++++
 tb/tb_wts_channel_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_channel_writer.sv
// -----------------------------------------------------------------------------
// wts_channel_writer
//
// Write side of the per-channel register bank in the wave table sound core.
// A CPU write arrives on a four-phase req/ack handshake, is buffered, and is
// committed into one of six channel registers (A-F). A write is held back
// while the time-slot generator is servicing the target channel, so the
// synthesis pipeline never sees a register change in the middle of a slot.
//
// Ports:
//   clk      system clock, rising edge
//   nreset   asynchronous active-low reset
//   active   channel slot being serviced (0-5 = A-F, 6/7 = idle slots)
//   wr_req   write request level, held with wr_ch/wr_data until wr_ack
//   wr_ch    target channel (0-5 = A-F, 6/7 = invalid, write discarded)
//   wr_data  write data
//   wr_ack   write acknowledge (registered)
//   busy     high while a write is outstanding (registered)
//   reg_a..reg_f  per-channel registers (registered)
// -----------------------------------------------------------------------------
module wts_channel_writer #(
   parameter int bits = 8
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [2:0]      active,
   input  logic            wr_req,
   input  logic [2:0]      wr_ch,
   input  logic [bits-1:0] wr_data,
   output logic            wr_ack,
   output logic            busy,
   output logic [bits-1:0] reg_a,
   output logic [bits-1:0] reg_b,
   output logic [bits-1:0] reg_c,
   output logic [bits-1:0] reg_d,
   output logic [bits-1:0] reg_e,
   output logic [bits-1:0] reg_f
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t          state_reg;
   logic [2:0]      ch_buf_reg;
   logic [bits-1:0] data_buf_reg;
   logic            wr_ack_reg;
   logic            busy_reg;

   logic            commit_ok;
   logic            commit_en;
   logic [bits-1:0] chan_q [6];

   // Invalid channels never touch a register, so they need not wait for
   // the slot generator to move on.
   assign commit_ok = (active != ch_buf_reg) || (ch_buf_reg >= 3'd6);
   assign commit_en = (state_reg == PENDING) && commit_ok;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_reg    <= IDLE;
         ch_buf_reg   <= '0;
         data_buf_reg <= '0;
         wr_ack_reg   <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (wr_req) begin
                  ch_buf_reg   <= wr_ch;
                  data_buf_reg <= wr_data;
                  busy_reg     <= 1'b1;
                  state_reg    <= PENDING;
               end
            end
            PENDING: begin
               if (commit_ok) begin
                  wr_ack_reg <= 1'b1;
                  state_reg  <= RELEASE;
               end
            end
            RELEASE: begin
               // Ack stays up until the requester drops wr_req, closing
               // the four-phase handshake.
               if (!wr_req) begin
                  wr_ack_reg <= 1'b0;
                  busy_reg   <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            default: begin
               wr_ack_reg <= 1'b0;
               busy_reg   <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

   // One register per channel; each loads only on a commit addressed to it.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_chan
         logic [bits-1:0] val_reg;

         always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
               val_reg <= '0;
            end else if (commit_en && (ch_buf_reg == 3'(gi))) begin
               val_reg <= data_buf_reg;
            end
         end

         assign chan_q[gi] = val_reg;
      end
   endgenerate

   assign wr_ack = wr_ack_reg;
   assign busy   = busy_reg;
   assign reg_a  = chan_q[0];
   assign reg_b  = chan_q[1];
   assign reg_c  = chan_q[2];
   assign reg_d  = chan_q[3];
   assign reg_e  = chan_q[4];
   assign reg_f  = chan_q[5];

endmodule

// File: tb/tb_wts_channel_writer.sv
// -----------------------------------------------------------------------------
// tb_wts_channel_writer
//
// Directed handshake scenarios followed by randomized writes with a randomly
// wandering active slot. A behavioural model tracks the outstanding write and
// the expected register bank; every falling edge the DUT outputs are compared
// against it. A few literal expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_wts_channel_writer;

   localparam int BITS = 8;

   logic            clk = 1'b0;
   logic            nreset;
   logic [2:0]      active = '0;
   logic            wr_req = 1'b0;
   logic [2:0]      wr_ch = '0;
   logic [BITS-1:0] wr_data = '0;
   logic            wr_ack;
   logic            busy;
   logic [BITS-1:0] reg_a, reg_b, reg_c, reg_d, reg_e, reg_f;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;
   bit rand_active = 1'b0;

   wts_channel_writer #(.bits(BITS)) dut (
      .clk     (clk),
      .nreset  (nreset),
      .active  (active),
      .wr_req  (wr_req),
      .wr_ch   (wr_ch),
      .wr_data (wr_data),
      .wr_ack  (wr_ack),
      .busy    (busy),
      .reg_a   (reg_a),
      .reg_b   (reg_b),
      .reg_c   (reg_c),
      .reg_d   (reg_d),
      .reg_e   (reg_e),
      .reg_f   (reg_f)
   );

   always #5 clk = ~clk;

   logic [BITS-1:0] dut_regs [6];
   assign dut_regs[0] = reg_a;
   assign dut_regs[1] = reg_b;
   assign dut_regs[2] = reg_c;
   assign dut_regs[3] = reg_d;
   assign dut_regs[4] = reg_e;
   assign dut_regs[5] = reg_f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A write is "outstanding" from capture until the requester drops wr_req
   // after seeing the ack; "acked" once it has been committed or discarded.
   bit              m_outstanding = 1'b0;
   bit              m_acked       = 1'b0;
   int              m_ch          = 0;
   logic [BITS-1:0] m_data        = '0;
   logic [BITS-1:0] m_regs [6]    = '{default: '0};

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m_outstanding = 1'b0;
         m_acked       = 1'b0;
         m_ch          = 0;
         m_data        = '0;
         for (int i = 0; i < 6; i++) m_regs[i] = '0;
      end else if (!m_outstanding) begin
         if (wr_req) begin
            m_outstanding = 1'b1;
            m_ch          = int'(wr_ch);
            m_data        = wr_data;
         end
      end else if (!m_acked) begin
         if (m_ch >= 6) begin
            m_acked = 1'b1;
         end else if (int'(active) != m_ch) begin
            m_regs[m_ch] = m_data;
            m_acked      = 1'b1;
         end
      end else if (!wr_req) begin
         m_outstanding = 1'b0;
         m_acked       = 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started) begin
         check("wr_ack", {31'd0, wr_ack}, {31'd0, m_acked});
         check("busy",   {31'd0, busy},   {31'd0, m_outstanding});
         for (int i = 0; i < 6; i++)
            check($sformatf("reg[%0d]", i), {24'd0, dut_regs[i]}, {24'd0, m_regs[i]});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      if (rand_active) active = 3'($urandom_range(0, 7));
   endtask

   task automatic rand_write(input logic [2:0] ch, input logic [BITS-1:0] data,
                             input int hold, input bit mangle);
      int lat;
      tick();
      wr_req  = 1'b1;
      wr_ch   = ch;
      wr_data = data;
      lat = 0;
      while (!wr_ack && lat < 200) begin
         tick();
         lat++;
      end
      check("ack_timeout", {31'd0, wr_ack}, 32'd1);
      if (mangle) begin
         wr_data = BITS'($urandom);
         wr_ch   = 3'($urandom_range(0, 7));
      end
      repeat (hold) tick();
      wr_req = 1'b0;
      for (int i = 0; i < 5 && busy; i++) tick();
      check("busy_release", {31'd0, busy}, 32'd0);
      $display("write ch=%0d data=%02h ack_latency=%0d hold=%0d mangle=%0d",
               ch, data, lat, hold, mangle);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      nreset = 1'b1;
      #1 nreset = 1'b0;
      started = 1'b1;

      // Reset with random inputs: everything must stay cleared.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         active  = 3'($urandom_range(0, 7));
         wr_req  = 1'($urandom);
         wr_ch   = 3'($urandom_range(0, 7));
         wr_data = BITS'($urandom);
      end
      @(negedge clk);
      check("rst_ack",  {31'd0, wr_ack}, 32'd0);
      check("rst_busy", {31'd0, busy},   32'd0);
      check("rst_reg_a", {24'd0, reg_a}, 32'd0);
      check("rst_reg_f", {24'd0, reg_f}, 32'd0);
      wr_req = 1'b0;
      nreset = 1'b1;
      tick();
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      $display("reset released");

      // Basic write: commit and ack visible after the second edge.
      active = 3'd3; wr_req = 1'b1; wr_ch = 3'd0; wr_data = 8'h5A;
      tick();
      check("basic_e1_busy", {31'd0, busy}, 32'd1);
      check("basic_e1_ack", {31'd0, wr_ack}, 32'd0);
      check("basic_e1_reg_a", {24'd0, reg_a}, 32'd0);
      tick();
      check("basic_e2_reg_a", {24'd0, reg_a}, 32'h5A);
      check("basic_e2_ack", {31'd0, wr_ack}, 32'd1);
      check("basic_e2_reg_b", {24'd0, reg_b}, 32'd0);
      wr_req = 1'b0;
      tick();
      check("basic_drop_ack", {31'd0, wr_ack}, 32'd0);
      check("basic_drop_busy", {31'd0, busy}, 32'd0);
      $display("write ch=0 data=5a basic");

      // Slot collision: stalled while active == target channel.
      active = 3'd2; wr_req = 1'b1; wr_ch = 3'd2; wr_data = 8'hC3;
      repeat (5) begin
         tick();
         check("coll_stall_reg_c", {24'd0, reg_c}, 32'd0);
         check("coll_stall_ack", {31'd0, wr_ack}, 32'd0);
      end
      active = 3'd3;
      tick();
      check("coll_commit_reg_c", {24'd0, reg_c}, 32'hC3);
      check("coll_commit_ack", {31'd0, wr_ack}, 32'd1);
      wr_req = 1'b0;
      tick();
      tick();
      $display("write ch=2 data=c3 collision");

      // Invalid channel, with active on an idle slot equal to the channel.
      active = 3'd7; wr_req = 1'b1; wr_ch = 3'd7; wr_data = 8'hFF;
      tick();
      tick();
      check("inv_ack", {31'd0, wr_ack}, 32'd1);
      check("inv_reg_a", {24'd0, reg_a}, 32'h5A);
      check("inv_reg_c", {24'd0, reg_c}, 32'hC3);
      check("inv_reg_f", {24'd0, reg_f}, 32'd0);
      wr_req = 1'b0;
      tick();
      tick();
      $display("write ch=7 data=ff invalid");

      // Handshake hygiene: data changes after capture are ignored.
      active = 3'd0; wr_req = 1'b1; wr_ch = 3'd1; wr_data = 8'h77;
      tick();
      tick();
      wr_data = 8'h11;
      repeat (10) begin
         tick();
         check("hyg_ack_hold", {31'd0, wr_ack}, 32'd1);
         check("hyg_reg_b", {24'd0, reg_b}, 32'h77);
      end
      wr_req = 1'b0;
      tick();
      check("hyg_drop_ack", {31'd0, wr_ack}, 32'd0);
      tick();
      $display("write ch=1 data=77 hygiene");

      // Reset mid-write: pending write on channel 4 is dropped.
      active = 3'd4; wr_req = 1'b1; wr_ch = 3'd4; wr_data = 8'hAB;
      tick();
      tick();
      check("midrst_pending_busy", {31'd0, busy}, 32'd1);
      #2 nreset = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_ack", {31'd0, wr_ack}, 32'd0);
      wr_req = 1'b0;
      tick();
      tick();
      nreset = 1'b1;
      repeat (6) begin
         tick();
         check("midrst_reg_e", {24'd0, reg_e}, 32'd0);
         check("midrst_no_ack", {31'd0, wr_ack}, 32'd0);
      end
      $display("write ch=4 data=ab dropped by reset");

      // Randomized writes with a wandering slot generator.
      rand_active = 1'b1;
      for (int n = 0; n < 80; n++) begin
         rand_write(3'($urandom_range(0, 7)), BITS'($urandom),
                    int'($urandom_range(0, 4)), 1'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_active = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
